// File: rtl/pipe_result_accum.sv
// pipe_result_accum
//   Groups the result stream of an upstream arithmetic pipeline into windows
//   of WIN samples. For each window it reports the unsigned sum and the
//   maximum sample through a one-deep output slot.
//
//   The upstream pipeline cannot stall, so every valid sample is accepted.
//   A completed window is dropped when the output slot is still occupied.
//   That drop sets the sticky overrun flag.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      synchronous reset, ACTIVE-HIGH (1 = reset; the name is historical)
//   in_valid   in_data carries a result this cycle
//   in_data    8-bit unsigned result
//   flush      discard the partial window (the output slot is unaffected)
//   out_ready  consumer takes out_sum/out_max this cycle
//   out_valid  out_sum/out_max hold a completed window
//   out_sum    SW-bit window sum
//   out_max    window maximum
//   overrun    sticky: a completed window was dropped; cleared only by reset
module pipe_result_accum #(
    parameter int WIN = 4,   // 2, 4, 8 or 16
    parameter int SW  = 12   // 16*255 fits in 12 bits
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    input  logic          flush,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [SW-1:0] out_sum,
    output logic [7:0]    out_max,
    output logic          overrun
);

    localparam int             CW   = $clog2(WIN);
    localparam logic [CW-1:0]  LAST = CW'(WIN - 1);

    logic [SW-1:0] acc_sum;
    logic [7:0]    acc_max;
    logic [CW-1:0] cnt;

    logic          done;
    logic          slot_free;
    logic [SW-1:0] final_sum;
    logic [7:0]    final_max;

    // The final values include the sample arriving this cycle.
    // As a result, the window result is ready on the edge after its last sample.
    always_comb begin
        final_sum = acc_sum + SW'(in_data);
        final_max = (in_data > acc_max) ? in_data : acc_max;
        done      = in_valid && !flush && (cnt == LAST);
        slot_free = !out_valid || out_ready;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            acc_sum   <= '0;
            acc_max   <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_max   <= '0;
            overrun   <= 1'b0;
        end else begin
            // Accumulator: flush wins over a simultaneous sample.
            if (flush || done) begin
                acc_sum <= '0;
                acc_max <= '0;
                cnt     <= '0;
            end else if (in_valid) begin
                acc_sum <= final_sum;
                acc_max <= final_max;
                cnt     <= cnt + 1'b1;
            end

            // Output slot: a completion in the consumer's accept cycle
            // replaces the old result rather than clearing out_valid.
            if (done && slot_free) begin
                out_valid <= 1'b1;
                out_sum   <= final_sum;
                out_max   <= final_max;
            end else if (done) begin
                overrun   <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pipe_result_accum.sv
// Directed bench for pipe_result_accum (WIN=4, SW=12).
// Inputs change 1 time unit after a rising edge.
// Outputs are sampled 1 time unit after the edge they were updated on.
module tb_pipe_result_accum;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        flush;
    logic        out_ready;
    logic        out_valid;
    logic [11:0] out_sum;
    logic [7:0]  out_max;
    logic        overrun;

    int total = 0;
    int bad   = 0;

    pipe_result_accum #(.WIN(4), .SW(12)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
        .out_sum(out_sum), .out_max(out_max), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Advance one edge, then settle past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One valid sample for one cycle.
    task automatic push(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; in_valid = 1'b1; in_data = 8'hAA; flush = 1'b1; out_ready = 1'b1;
        step(); step();
        total++;
        if ({out_valid, out_sum, out_max, overrun} !== {1'b0, 12'h000, 8'h00, 1'b0}) begin
            bad++;
            $display("FAIL reset: got v=%b sum=%h max=%h ovr=%b, want 0 000 00 0",
                     out_valid, out_sum, out_max, overrun);
        end
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; flush = 1'b0;
        step();
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        push(8'h05); push(8'h0C); push(8'h03);
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL basic_early: out_valid=%b want 0", out_valid);
        end
        push(8'h01);
        total++;
        if ({out_valid, out_sum, out_max, overrun} !== {1'b1, 12'h015, 8'h0C, 1'b0}) begin
            bad++;
            $display("FAIL basic: got v=%b sum=%h max=%h ovr=%b, want 1 015 0c 0",
                     out_valid, out_sum, out_max, overrun);
        end
        step();
        total++;
        if ({out_valid, out_sum, out_max} !== {1'b0, 12'h015, 8'h0C}) begin
            bad++;
            $display("FAIL basic_drain: got v=%b sum=%h max=%h, want 0 015 0c",
                     out_valid, out_sum, out_max);
        end
    endtask

    task automatic test_max();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(8'hFF);
        total++;
        if ({out_valid, out_sum, out_max, overrun} !== {1'b1, 12'h3FC, 8'hFF, 1'b0}) begin
            bad++;
            $display("FAIL max_ff: got v=%b sum=%h max=%h ovr=%b, want 1 3fc ff 0",
                     out_valid, out_sum, out_max, overrun);
        end
        step();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(8'h01);
        out_ready = 1'b0;
        push(8'h02); push(8'h03); push(8'h04);
        total++;
        if ({out_valid, out_sum, out_max} !== {1'b1, 12'h004, 8'h01}) begin
            bad++;
            $display("FAIL b2b_hold: got v=%b sum=%h max=%h, want 1 004 01",
                     out_valid, out_sum, out_max);
        end
        out_ready = 1'b1;
        push(8'h05);
        total++;
        if ({out_valid, out_sum, out_max, overrun} !== {1'b1, 12'h00E, 8'h05, 1'b0}) begin
            bad++;
            $display("FAIL b2b_replace: got v=%b sum=%h max=%h ovr=%b, want 1 00e 05 0",
                     out_valid, out_sum, out_max, overrun);
        end
        step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL b2b_drain: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        push(8'h10); push(8'h20);
        flush = 1'b1;
        push(8'h30);
        flush = 1'b0;
        push(8'h01); push(8'h02); push(8'h03);
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL flush_early: out_valid=%b want 0", out_valid);
        end
        push(8'h04);
        total++;
        if ({out_valid, out_sum, out_max} !== {1'b1, 12'h00A, 8'h04}) begin
            bad++;
            $display("FAIL flush: got v=%b sum=%h max=%h, want 1 00a 04",
                     out_valid, out_sum, out_max);
        end
        step();
    endtask

    task automatic test_overrun();
        out_ready = 1'b0;
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        push(8'h09); push(8'h09); push(8'h09); push(8'h09);
        total++;
        if ({out_valid, out_sum, out_max, overrun} !== {1'b1, 12'h00A, 8'h04, 1'b1}) begin
            bad++;
            $display("FAIL overrun: got v=%b sum=%h max=%h ovr=%b, want 1 00a 04 1",
                     out_valid, out_sum, out_max, overrun);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        total++;
        if ({out_valid, overrun} !== 2'b01) begin
            bad++;
            $display("FAIL overrun_drain: got v=%b ovr=%b, want 0 1", out_valid, overrun);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        total++;
        if ({out_valid, out_sum, out_max, overrun} !== {1'b0, 12'h00A, 8'h04, 1'b1}) begin
            bad++;
            $display("FAIL overrun_flush: got v=%b sum=%h max=%h ovr=%b, want 0 00a 04 1",
                     out_valid, out_sum, out_max, overrun);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(8'h07);
        push(8'h50); push(8'h60);
        total++;
        if ({out_valid, out_sum} !== {1'b1, 12'h01C}) begin
            bad++; $display("FAIL pre_reset: got v=%b sum=%h, want 1 01c", out_valid, out_sum);
        end
        rst_n = 1'b1; in_valid = 1'b1; in_data = 8'hFF; flush = 1'b0; out_ready = 1'b1;
        step();
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        total++;
        if ({out_valid, out_sum, out_max, overrun} !== {1'b0, 12'h000, 8'h00, 1'b0}) begin
            bad++;
            $display("FAIL mid_reset: got v=%b sum=%h max=%h ovr=%b, want 0 000 00 0",
                     out_valid, out_sum, out_max, overrun);
        end
        push(8'h02); push(8'h02);
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL post_reset_early: out_valid=%b want 0", out_valid);
        end
        push(8'h02); push(8'h02);
        total++;
        if ({out_valid, out_sum, out_max, overrun} !== {1'b1, 12'h008, 8'h02, 1'b0}) begin
            bad++;
            $display("FAIL post_reset: got v=%b sum=%h max=%h ovr=%b, want 1 008 02 0",
                     out_valid, out_sum, out_max, overrun);
        end
    endtask

    initial begin
        rst_n = 1'b1; in_valid = 1'b0; in_data = 8'h00; flush = 1'b0; out_ready = 1'b0;
        test_reset();
        test_basic();
        test_max();
        test_back_to_back();
        test_flush();
        test_overrun();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
